// File: rtl/data_mem_ws_pkg.sv
// data_mem_ws_pkg
// Shared definitions for the wait-state data memory:
//   xfer_t     - access type encodings carried on req_type
//   state_t    - request FSM states (exposed on dbg_state)
//   xfer_bad() - type legality and natural-alignment check
package data_mem_ws_pkg;

   typedef enum logic [2:0] {
      XT_B  = 3'b000,
      XT_H  = 3'b001,
      XT_W  = 3'b010,
      XT_BU = 3'b100,
      XT_HU = 3'b101
   } xfer_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // High when the access is illegal or misaligned. Unsigned variants exist
   // only for loads, so a BU/HU store is illegal as well.
   function automatic logic xfer_bad(input logic [2:0] xt, input logic wr,
                                     input logic [1:0] addr_lo);
      logic bad;
      case (xt)
         XT_B:    bad = 1'b0;
         XT_H:    bad = addr_lo[0];
         XT_W:    bad = (addr_lo != 2'b00);
         XT_BU:   bad = wr;
         XT_HU:   bad = wr | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_ws_ram.sv
// data_mem_ws_ram
// Byte-enabled 32-bit synchronous RAM, WORDS deep, no reset.
//   CLK   - clock
//   we/be - write enable and per-byte lane enables
//   re    - read enable; rdata updates on the same edge
//   addr  - word index
//   wdata - write data (lane-aligned)
//   rdata - registered read data
module data_mem_ws_ram #(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge CLK) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_ws.sv
// data_mem_ws
// Byte-addressed little-endian data memory with LATENCY wait states.
// Handshake: a request is accepted on a CLK edge where req_valid && req_ready;
// its fields are captured then and later input changes are ignored. Exactly
// one rsp_valid pulse follows, LATENCY+1 cycles after the accepting edge.
//   CLK, Reset          - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake (ready in IDLE and RESP)
//   req_wr/addr/type    - store flag, byte address, access type
//   req_wdata           - store data, low bytes used for B/H
//   rsp_valid/data/err  - response pulse, load data, error flag
//   dbg_state           - current FSM state
module data_mem_ws
   import data_mem_ws_pkg::*;
#(
   parameter int DEPTH_BYTES = 4096,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_type,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic [1:0]        dbg_state
);

   localparam int AB = $clog2(DEPTH_BYTES);
   localparam logic [2:0] LAT_M1 = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

   state_t         state, state_nxt;
   logic [2:0]     cnt;
   logic           wr_q, err_q;
   logic [AB-1:0]  addr_q;
   logic [2:0]     type_q;
   logic [31:0]    wdata_q;

   logic           accept, new_err, enter_resp;
   logic           cur_wr, cur_err;
   logic [AB-1:0]  cur_addr;
   logic [2:0]     cur_type;
   logic [31:0]    cur_wdata, lane_wdata, ram_rdata, shifted, load_val;
   logic [3:0]     lane_be;

   assign accept  = req_valid && req_ready;
   // Upper address bits only feed the range check.
   assign new_err = xfer_bad(req_type, req_wr, req_addr[1:0]) ||
                    ((req_addr >> AB) != '0);

   // The access that commits on the coming edge: the request being accepted
   // right now (LATENCY=0 path) or the one already held in WAIT.
   assign cur_wr    = accept ? req_wr    : wr_q;
   assign cur_err   = accept ? new_err   : err_q;
   assign cur_addr  = accept ? req_addr[AB-1:0] : addr_q;
   assign cur_type  = accept ? req_type  : type_q;
   assign cur_wdata = accept ? req_wdata : wdata_q;

   // Storage is touched only on the edge entering RESP.
   assign enter_resp = (state_nxt == ST_RESP);

   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = cur_wdata;
      case (cur_type)
         XT_B, XT_BU: begin
            lane_be    = 4'b0001 << cur_addr[1:0];
            lane_wdata = {4{cur_wdata[7:0]}};
         end
         XT_H, XT_HU: begin
            lane_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{cur_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   data_mem_ws_ram #(.WORDS(DEPTH_BYTES / 4), .AW(AB - 2)) u_ram (
      .CLK   (CLK),
      .we    (enter_resp && cur_wr && !cur_err),
      .be    (lane_be),
      .re    (enter_resp && !cur_wr && !cur_err),
      .addr  (cur_addr[AB-1:2]),
      .wdata (lane_wdata),
      .rdata (ram_rdata)
   );

   // State register
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_RESP: begin
            if (accept) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            else        state_nxt = ST_IDLE;
         end
         ST_WAIT: if (cnt == 3'd0) state_nxt = ST_RESP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Wait counter and request capture
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         cnt     <= 3'd0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         type_q  <= 3'd0;
         wdata_q <= 32'd0;
      end else begin
         if (accept) begin
            cnt     <= LAT_M1;
            wr_q    <= req_wr;
            err_q   <= new_err;
            addr_q  <= req_addr[AB-1:0];
            type_q  <= req_type;
            wdata_q <= req_wdata;
         end else if (state == ST_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
      end
   end

   // Little-endian extraction of the addressed byte/halfword.
   assign shifted = ram_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_val = ram_rdata;
      case (type_q)
         XT_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
         XT_BU:   load_val = {24'd0, shifted[7:0]};
         XT_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
         XT_HU:   load_val = {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = 32'd0;
      rsp_err   = 1'b0;
      case (state)
         ST_IDLE: req_ready = !Reset;
         ST_RESP: begin
            req_ready = !Reset;
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!wr_q && !err_q) rsp_data = load_val;
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

endmodule
